// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: byte input and decoded key-event bus of the PS/2 scan code decoder
interface ps2_scancode_decoder_if;
    logic       data_ena;
    logic [7:0] data_in;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;
    logic       evt_rd;
    logic [7:0] last_make;
    logic       err;
    logic       ovf;
    modport master (
        output data_ena, data_in, evt_rd,
        input  evt_valid, evt_code, evt_ext, evt_brk, last_make, err, ovf
    );
    modport slave (
        input  data_ena, data_in, evt_rd,
        output evt_valid, evt_code, evt_ext, evt_brk, last_make, err, ovf
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: E0/F0 prefix decoder with prefix timeout feeding a first-word-fall-through event FIFO
module ps2_scancode_decoder #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input logic                   app_clk,
    input logic                   app_arst_n,
    ps2_scancode_decoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t          st, nxt;
    logic [TW-1:0]   tcnt;
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   cnt;
    logic [9:0]      mem [DEPTH];
    logic [9:0]      head;
    logic            push, perr, ext, brk, is_e0, is_f0, drop, full, pop, wr;
    logic [7:0]      last_make_q;
    logic            err_q, ovf_q;
    assign is_e0 = bus.data_in == 8'hE0;
    assign is_f0 = bus.data_in == 8'hF0;
    assign drop  = bus.data_in inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    always_comb begin
        nxt  = st;
        push = 1'b0;
        perr = 1'b0;
        ext  = 1'b0;
        brk  = 1'b0;
        if (bus.data_ena) begin
            case (st)
                IDLE: begin
                    nxt  = is_e0 ? EXT : is_f0 ? BRK : IDLE;
                    push = !(is_e0 || is_f0 || drop);
                end
                EXT: begin
                    nxt  = is_f0 ? EXT_BRK : is_e0 ? EXT : IDLE;
                    push = !(is_e0 || is_f0);
                    ext  = 1'b1;
                end
                default: begin
                    nxt  = IDLE;
                    perr = is_e0 || is_f0;
                    push = !(is_e0 || is_f0);
                    ext  = st == EXT_BRK;
                    brk  = 1'b1;
                end
            endcase
        end else if (st != IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
            nxt  = IDLE;
            perr = 1'b1;
        end
    end
    assign full = cnt == CW'(DEPTH);
    assign pop  = bus.evt_rd && cnt != '0;
    assign wr   = push && (!full || pop);
    always_ff @(posedge app_clk or negedge app_arst_n) begin
        if (!app_arst_n) begin
            st          <= IDLE;
            tcnt        <= '0;
            wptr        <= '0;
            rptr        <= '0;
            cnt         <= '0;
            last_make_q <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            st          <= nxt;
            tcnt        <= (bus.data_ena || st == IDLE) ? '0 : tcnt + 1'b1;
            wptr        <= wr ? wptr + 1'b1 : wptr;
            rptr        <= pop ? rptr + 1'b1 : rptr;
            cnt         <= cnt + CW'(wr) - CW'(pop);
            last_make_q <= (wr && !brk) ? bus.data_in : last_make_q;
            err_q       <= perr;
            ovf_q       <= push && full && !pop;
        end
    end
    // Entry layout {ext, brk, code}; storage needs no reset because outputs are gated by occupancy
    always_ff @(posedge app_clk) begin
        if (wr) mem[wptr] <= {ext, brk, bus.data_in};
    end
    assign head          = mem[rptr];
    assign bus.evt_valid = cnt != '0;
    assign bus.evt_code  = bus.evt_valid ? head[7:0] : '0;
    assign bus.evt_ext   = bus.evt_valid && head[9];
    assign bus.evt_brk   = bus.evt_valid && head[8];
    assign bus.last_make = last_make_q;
    assign bus.err       = err_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed byte streams with an expected-event queue checked by a consumer process
module tb_ps2_scancode_decoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    bit         rd_en = 1'b0;
    int         checks = 0, failures = 0, err_cnt = 0, ovf_cnt = 0, e0 = 0;
    logic [9:0] exp_q [$];
    ps2_scancode_decoder_if ifc ();
    ps2_scancode_decoder #(.DEPTH(4), .TIMEOUT_CYC(20)) dut (
        .app_clk   (clk),
        .app_arst_n(rst_n),
        .bus       (ifc.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1 ifc.data_ena = 1'b1;
        ifc.data_in = b;
        @(posedge clk);
        #1 ifc.data_ena = 1'b0;
    endtask
    task automatic send_ev(input logic [7:0] b, input logic e, input logic k);
        exp_q.push_back({e, k, b});
        @(posedge clk);
        #1 chk("pre_valid", ifc.evt_valid, 0);
        ifc.data_ena = 1'b1;
        ifc.data_in = b;
        @(posedge clk);
        #1 ifc.data_ena = 1'b0;
        chk("lat_valid", ifc.evt_valid, 1);
    endtask
    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain", exp_q.size(), 0);
    endtask
    initial begin
        ifc.evt_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.evt_valid && rd_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_evt: got %0h expected none", {ifc.evt_ext, ifc.evt_brk, ifc.evt_code});
                end else chk("evt", {ifc.evt_ext, ifc.evt_brk, ifc.evt_code}, exp_q.pop_front());
                ifc.evt_rd = 1'b1;
            end else ifc.evt_rd = 1'b0;
        end
    end
    initial forever begin
        @(negedge clk);
        if (ifc.err) err_cnt++;
        if (ifc.ovf) ovf_cnt++;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        ifc.data_ena = 1'b0;
        ifc.data_in  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_valid", ifc.evt_valid, 0);
        chk("rst_code", ifc.evt_code, 0);
        chk("rst_ext", ifc.evt_ext, 0);
        chk("rst_brk", ifc.evt_brk, 0);
        chk("rst_last_make", ifc.last_make, 0);
        chk("rst_err", ifc.err, 0);
        chk("rst_ovf", ifc.ovf, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_en = 1'b1;
        send_ev(8'h1C, 1'b0, 1'b0);
        send(8'hF0);
        send_ev(8'h1C, 1'b0, 1'b1);
        drain();
        chk("last_make_1c", ifc.last_make, 8'h1C);
        chk("no_err_basic", err_cnt, 0);
        send(8'hE0);
        send_ev(8'h75, 1'b1, 1'b0);
        send(8'hAA);
        send(8'hE0);
        send(8'hF0);
        send_ev(8'h75, 1'b1, 1'b1);
        send(8'hFA);
        drain();
        chk("no_err_ext", err_cnt, 0);
        chk("last_make_75", ifc.last_make, 8'h75);
        e0 = err_cnt;
        send(8'hF0);
        repeat (10) @(posedge clk);
        chk("err_early", err_cnt, e0);
        repeat (15) @(posedge clk);
        chk("err_timeout", err_cnt, e0 + 1);
        send_ev(8'h15, 1'b0, 1'b0);
        drain();
        rd_en = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({2'b00, 8'(i)});
            send(8'(i));
        end
        send(8'h05);
        repeat (2) @(posedge clk);
        chk("ovf_full", ovf_cnt, 1);
        chk("last_make_full", ifc.last_make, 8'h04);
        chk("hold_valid", ifc.evt_valid, 1);
        chk("hold_code", ifc.evt_code, 8'h01);
        exp_q.push_back({2'b00, 8'h06});
        @(posedge clk);
        #1 rd_en = 1'b1;
        ifc.data_ena = 1'b1;
        ifc.data_in = 8'h06;
        @(posedge clk);
        #1 ifc.data_ena = 1'b0;
        drain();
        chk("ovf_full_rw", ovf_cnt, 1);
        chk("last_make_06", ifc.last_make, 8'h06);
        e0 = err_cnt;
        send(8'hF0);
        send(8'hE0);
        repeat (2) @(posedge clk);
        chk("err_f0e0", err_cnt, e0 + 1);
        chk("no_evt_f0e0", ifc.evt_valid, 0);
        rd_en = 1'b0;
        @(negedge clk);
        send(8'h33);
        send(8'hE0);
        @(negedge clk);
        chk("pre_rst_valid", ifc.evt_valid, 1);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_valid", ifc.evt_valid, 0);
        end
        chk("midrst_last_make", ifc.last_make, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd_en = 1'b1;
        send_ev(8'h1C, 1'b0, 1'b0);
        drain();
        chk("last_make_post_rst", ifc.last_make, 8'h1C);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
